// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester and its helpers.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Command captured at acceptance and replayed onto PWRITE/PADDR/PWDATA.
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating count of consecutive not-ready ACCESS cycles; flags the cycle
// that reaches TIMEOUT_CYCLES so the requester can abort in that same cycle.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // r_cnt holds the not-ready cycles already seen, so this one is number r_cnt+1.
  assign o_expire_c = (TIMEOUT_CYCLES != 0) && i_inc && (r_cnt == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on
// the bus, one response pulse per command with a wait-state timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              apb_sel,
  output logic              apb_enable,
  output logic              apb_write,
  output logic [ADDR_W-1:0] apb_addr,
  output logic [DATA_W-1:0] apb_wdata,
  input  logic [DATA_W-1:0] apb_rdata,
  input  logic              apb_ready,
  input  logic              apb_slverr
);

  apb_state_t        r_state;
  apb_cmd_t          r_cmd;
  logic              r_sel;
  logic              r_enable;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic w_accept;
  logic w_wait;
  logic w_expire;

  assign cmd_ready = (r_state == IDLE) && !reset;
  assign w_accept  = (r_state == IDLE) && cmd_valid;
  assign w_wait    = (r_state == ACCESS) && !apb_ready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_clear    (w_accept),
    .i_inc      (w_wait),
    .o_expire_c (w_expire)
  );

  // Command fields stay in r_cmd after completion, so the bus idles on its last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_sel       <= 1'b0;
      r_enable    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_cmd.write <= cmd_write;
            r_cmd.addr  <= APB_ADDR_W'(cmd_addr);
            r_cmd.wdata <= APB_DATA_W'(cmd_wdata);
            r_sel       <= 1'b1;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          r_enable <= 1'b1;
          r_state  <= ACCESS;
        end
        ACCESS: begin
          if (apb_ready || w_expire) begin
            r_sel       <= 1'b0;
            r_enable    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !apb_ready || apb_slverr;
            r_rsp_rdata <= (apb_ready && !apb_slverr && !r_cmd.write) ? apb_rdata : '0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_sel    <= 1'b0;
          r_enable <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign apb_sel    = r_sel;
  assign apb_enable = r_enable;
  assign apb_write  = r_cmd.write;
  assign apb_addr   = ADDR_W'(r_cmd.addr);
  assign apb_wdata  = DATA_W'(r_cmd.wdata);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a simple memory slave on the APB side, a
// vector table, a back-to-back/reset sequence and a randomized command stream.
module tb_apb_master_bridge;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        apb_sel;
  logic        apb_enable;
  logic        apb_write;
  logic [7:0]  apb_addr;
  logic [31:0] apb_wdata;
  logic [31:0] apb_rdata;
  logic        apb_ready;
  logic        apb_slverr;

  int total = 0;
  int bad   = 0;

  logic [31:0] slv_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        slv_init;

  apb_master_bridge #(
    .ADDR_W(8),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .apb_sel    (apb_sel),
    .apb_enable (apb_enable),
    .apb_write  (apb_write),
    .apb_addr   (apb_addr),
    .apb_wdata  (apb_wdata),
    .apb_rdata  (apb_rdata),
    .apb_ready  (apb_ready),
    .apb_slverr (apb_slverr)
  );

  always #5 clk = ~clk;

  // Memory slave: write lands only on an error-free, ready ACCESS cycle.
  always @(posedge clk) begin
    if (slv_init) begin
      for (int i = 0; i < 256; i++) slv_mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (apb_sel && apb_enable && apb_ready && apb_write && !apb_slverr) begin
      slv_mem[apb_addr] <= apb_wdata;
    end
  end
  assign apb_rdata = slv_mem[apb_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One command from an idle bus; cycle 0 is the acceptance cycle.
  task automatic run_cmd(input bit w, input logic [7:0] a, input logic [31:0] d,
                         input int waits, input bit serr,
                         input bit e_err, input logic [31:0] e_rd);
    int n_acc;
    int rsp_c;
    n_acc = (waits < int'(TMO)) ? waits + 1 : int'(TMO);
    rsp_c = 2 + n_acc;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_sel", 32'(apb_sel), 32'd0);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_addr   = a;
    cmd_wdata  = d;
    apb_ready  = 1'b1;
    apb_slverr = 1'b0;
    for (int c = 1; c <= rsp_c; c++) begin
      @(negedge clk);
      chk($sformatf("sel_c%0d", c), 32'(apb_sel), 32'(c < rsp_c));
      chk($sformatf("enable_c%0d", c), 32'(apb_enable), 32'(c >= 2 && c < rsp_c));
      chk($sformatf("rsp_valid_c%0d", c), 32'(rsp_valid), 32'(c == rsp_c));
      chk($sformatf("cmd_ready_c%0d", c), 32'(cmd_ready), 32'(c == rsp_c));
      chk($sformatf("addr_c%0d", c), 32'(apb_addr), 32'(a));
      chk($sformatf("write_c%0d", c), 32'(apb_write), 32'(w));
      if (c < rsp_c) begin
        chk($sformatf("wdata_c%0d", c), apb_wdata, d);
      end else begin
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("rsp_rdata", rsp_rdata, e_rd);
      end
      // Conflicting command held while busy must be ignored.
      cmd_valid = (c < rsp_c);
      cmd_write = ~w;
      cmd_addr  = a ^ 8'hFF;
      cmd_wdata = ~d;
      if (c >= 2 && c < rsp_c) begin
        apb_ready  = (c - 2 >= waits);
        apb_slverr = serr;
      end else begin
        apb_ready  = 1'b1;
        apb_slverr = 1'b0;
      end
    end
    cmd_valid  = 1'b0;
    apb_ready  = 1'b1;
    apb_slverr = 1'b0;
    if (w && waits < int'(TMO) && !serr) ref_mem[a] = d;
  endtask

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    int          waits;
    bit          serr;
    bit          e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [11];

  logic [7:0]  b2b_addr [4];
  logic [31:0] b2b_data [4];
  bit          b2b_wr   [4];

  initial begin : main
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    int          waits;
    int          r;
    bit          serr;
    bit          e_err;
    logic [31:0] e_rd;

    reset      = 1'b1;
    slv_init   = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    apb_ready  = 1'b1;
    apb_slverr = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);

    vt[0]  = '{1'b1, 8'h10, 32'hDEAD_BEEF, 0,  1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 8'h10, 32'h0,         0,  1'b0, 1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{1'b0, 8'h10, 32'h0,         3,  1'b0, 1'b0, 32'hDEAD_BEEF};
    vt[3]  = '{1'b0, 8'h10, 32'h0,         20, 1'b0, 1'b1, 32'h0};
    vt[4]  = '{1'b1, 8'h20, 32'h0000_1234, 0,  1'b0, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 8'h20, 32'h0,         0,  1'b1, 1'b1, 32'h0};
    vt[6]  = '{1'b0, 8'h20, 32'h0,         1,  1'b0, 1'b0, 32'h0000_1234};
    vt[7]  = '{1'b1, 8'h30, 32'h5555_5555, 2,  1'b1, 1'b1, 32'h0};
    vt[8]  = '{1'b0, 8'h30, 32'h0,         0,  1'b0, 1'b0, 32'hA500_0030};
    vt[9]  = '{1'b1, 8'h10, 32'hCAFE_F00D, 16, 1'b0, 1'b1, 32'h0};
    vt[10] = '{1'b0, 8'h10, 32'h0,         15, 1'b0, 1'b0, 32'hDEAD_BEEF};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_sel", 32'(apb_sel), 32'd0);
    chk("rst_enable", 32'(apb_enable), 32'd0);
    chk("rst_write", 32'(apb_write), 32'd0);
    chk("rst_addr", 32'(apb_addr), 32'd0);
    chk("rst_wdata", apb_wdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    reset    = 1'b0;
    slv_init = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_cmd(vt[i].w, vt[i].a, vt[i].d, vt[i].waits, vt[i].serr, vt[i].e_err, vt[i].e_rd);
    end

    // Back-to-back with cmd_valid held, then reset during the 4th command's ACCESS.
    b2b_addr = '{8'h40, 8'h41, 8'h42, 8'h40};
    b2b_data = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h0};
    b2b_wr   = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c <= 9) begin
        chk($sformatf("b2b_ready_c%0d", c), 32'(cmd_ready), 32'(c % 3 == 0));
        chk($sformatf("b2b_sel_c%0d", c), 32'(apb_sel), 32'(c % 3 != 0));
        chk($sformatf("b2b_rsp_c%0d", c), 32'(rsp_valid), 32'(c == 3 || c == 6 || c == 9));
        if (c % 3 == 1) chk($sformatf("b2b_addr_c%0d", c), 32'(apb_addr), 32'(b2b_addr[c / 3]));
      end else if (c <= 11) begin
        chk($sformatf("b2b_sel_c%0d", c), 32'(apb_sel), 32'd1);
        chk($sformatf("b2b_ready_c%0d", c), 32'(cmd_ready), 32'd0);
        chk($sformatf("b2b_addr_c%0d", c), 32'(apb_addr), 32'h40);
        chk($sformatf("b2b_write_c%0d", c), 32'(apb_write), 32'd0);
      end else if (c == 12) begin
        chk("rstmid_sel", 32'(apb_sel), 32'd0);
        chk("rstmid_enable", 32'(apb_enable), 32'd0);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rstmid_addr", 32'(apb_addr), 32'd0);
      end else begin
        chk("rstmid_after_ready", 32'(cmd_ready), 32'd1);
        chk("rstmid_after_rsp", 32'(rsp_valid), 32'd0);
        chk("rstmid_after_sel", 32'(apb_sel), 32'd0);
      end
      if (c % 3 == 0 && c <= 9) begin
        cmd_valid = 1'b1;
        cmd_write = b2b_wr[c / 3];
        cmd_addr  = b2b_addr[c / 3];
        cmd_wdata = b2b_data[c / 3];
      end
      if (c == 10) cmd_valid = 1'b0;
      if (c == 11) reset = 1'b1;
      if (c == 12) reset = 1'b0;
    end
    for (int i = 0; i < 3; i++) ref_mem[b2b_addr[i]] = b2b_data[i];
    run_cmd(1'b0, 8'h41, 32'h0, 0, 1'b0, 1'b0, ref_mem[8'h41]);

    // Randomized commands against the memory reference.
    for (int n = 0; n < 40; n++) begin
      w = bit'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15));
      d = $urandom;
      r = int'($urandom_range(0, 9));
      if (r < 6)      waits = 0;
      else if (r < 9) waits = int'($urandom_range(1, 4));
      else            waits = int'($urandom_range(15, 18));
      serr  = ($urandom_range(0, 7) == 0);
      e_err = serr || (waits >= int'(TMO));
      e_rd  = (!w && !e_err) ? ref_mem[a] : 32'h0;
      run_cmd(w, a, d, waits, serr, e_err, e_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "bench did not finish");
  end

endmodule
